// File: rtl/multu_unit_pkg.sv
// rtl/multu_unit_pkg.sv - shared funct codes, sizes and FSM state encoding for multu_unit
package multu_unit_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = 6;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

    // 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/multu_datapath.sv
// rtl/multu_datapath.sv - shift-add multiplier registers (mcand/mplier/prod) with load/step control
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   load         capture operands and clear the product
//   step         one shift-add iteration
//   a, b         multiplicand / multiplier operands
//   prod         running 2*WIDTH-bit product
module multu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
        end else if (step) begin
            // Carry out of the top bit is dropped; it cannot occur for WIDTH x WIDTH.
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/multu_unit.sv
// rtl/multu_unit.sv - multi-cycle unsigned multiplier with HI/LO registers for the EX stage
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   dataA, dataB multiplicand (rs) / multiplier (rt)
//   Signal       funct code from ID/EX
//   valid        ID/EX holds a real instruction
//   dataOut      HI on MFHI, LO on MFLO, else 0
//   busy         multiply in progress (RUN or FIN)
//   done         one-cycle pulse while HI/LO load the new product
module multu_unit
    import multu_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    input  logic             valid,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] prod;
    logic               load;
    logic               step;

    multu_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .a    (dataA),
        .b    (dataB),
        .prod (prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // IDLE is also the fall-through for the unused encoding, so a stray
    // state recovers on the next edge and can still accept a MULTU.
    always_comb begin
        next_state = IDLE;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            RUN: begin
                step       = 1'b1;
                next_state = (count == CNT_W'(WIDTH - 1)) ? FIN : RUN;
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                if (valid && (Signal == MULTU)) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIN) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
        end
    end

    assign busy = (state == RUN) || (state == FIN);
    assign done = (state == FIN);

    always_comb begin
        dataOut = '0;
        if (Signal == MFHI) begin
            dataOut = hi;
        end else if (Signal == MFLO) begin
            dataOut = lo;
        end
    end

endmodule

// File: tb/tb_multu_unit.sv
// tb/tb_multu_unit.sv - self-checking bench for multu_unit against a behavioural product model
module tb_multu_unit;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic [5:0]  Signal = '0;
    logic        valid = 1'b0;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;

    int tests  = 0;
    int errors = 0;
    int done_seen = 0;
    int busy_seen = 0;

    // Model: a multiply occupies the unit for 33 cycles after its start edge;
    // the last of those is the done cycle, and HI/LO hold the product afterwards.
    int          rem   = 0;
    logic [63:0] mprod = '0;
    logic [31:0] mhi   = '0;
    logic [31:0] mlo   = '0;

    multu_unit dut (
        .clk     (clk),
        .rst     (rst),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .valid   (valid),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem = 0;
            mhi = '0;
            mlo = '0;
        end else if (rem > 0) begin
            rem = rem - 1;
            if (rem == 0) begin
                mhi = mprod[63:32];
                mlo = mprod[31:0];
            end
        end else if (valid && (Signal == F_MULTU)) begin
            rem   = 33;
            mprod = {32'b0, dataA} * {32'b0, dataB};
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] exp_out;
        exp_out = (Signal == F_MFHI) ? mhi : (Signal == F_MFLO) ? mlo : 32'h0;
        check1("busy", busy, rem != 0);
        check1("done", done, rem == 1);
        check32("dataOut", dataOut, exp_out);
        if (done) done_seen++;
        if (busy) busy_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        dataA  = a;
        dataB  = b;
        valid  = 1'b1;
        Signal = F_MULTU;
        tick();
        valid  = 1'b0;
        Signal = 6'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rem != 0 && n < 100) begin
            tick();
            n++;
        end
        check1("wait_idle_bound", rem == 0, 1'b1);
    endtask

    task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        Signal = F_MFHI;
        #1;
        check32({name, "_hi"}, dataOut, exp_hi);
        Signal = F_MFLO;
        #1;
        check32({name, "_lo"}, dataOut, exp_lo);
        check32({name, "_model_lo"}, mlo, exp_lo);
        Signal = 6'h00;
    endtask

    initial begin
        #1;
        // 1: reset with arbitrary inputs
        rst    = 1'b0;
        dataA  = 32'hDEADBEEF;
        dataB  = 32'h12345678;
        valid  = 1'b1;
        Signal = F_MULTU;
        repeat (3) tick();
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        read_hilo("reset", 32'h0, 32'h0);
        valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // 2: 3 x 5, busy span and single done
        done_seen = 0;
        busy_seen = 0;
        issue(32'd3, 32'd5);
        wait_idle();
        check32("busy_cycles_3x5", busy_seen, 33);
        check32("done_pulses_3x5", done_seen, 1);
        read_hilo("mul_3x5", 32'h0, 32'd15);

        // 3: boundary operands
        issue(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        read_hilo("mul_max", 32'hFFFFFFFE, 32'h00000001);
        issue(32'h80000000, 32'd2);
        wait_idle();
        read_hilo("mul_msb", 32'h1, 32'h0);

        // 4: MULTU and new operands held during a run are ignored
        done_seen = 0;
        issue(32'd3, 32'd5);
        repeat (20) begin
            dataA  = 32'd7;
            dataB  = 32'd9;
            valid  = 1'b1;
            Signal = F_MULTU;
            tick();
        end
        valid  = 1'b0;
        Signal = 6'h00;
        wait_idle();
        check32("done_pulses_ignored", done_seen, 1);
        read_hilo("mul_ignored", 32'h0, 32'd15);

        // 5: reset aborts a run, then the multiply re-issues
        issue(32'd2, 32'd2);
        wait_idle();
        read_hilo("mul_2x2", 32'h0, 32'd4);
        done_seen = 0;
        issue(32'd6, 32'd6);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        read_hilo("abort", 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check32("abort_no_done", done_seen, 0);
        issue(32'd6, 32'd6);
        wait_idle();
        read_hilo("mul_6x6", 32'h0, 32'd36);

        // 6: bubble never starts; MFLO during a run reads the old LO
        valid  = 1'b0;
        Signal = F_MULTU;
        repeat (5) tick();
        check1("bubble_busy", busy, 1'b0);
        issue(32'd4, 32'd4);
        repeat (5) tick();
        Signal = F_MFLO;
        #1;
        check32("run_mflo_old", dataOut, 32'd36);
        Signal = 6'h20;
        #1;
        check32("run_other_funct", dataOut, 32'h0);
        Signal = 6'h00;
        wait_idle();
        read_hilo("mul_4x4", 32'h0, 32'd16);

        // Random traffic, checked every cycle against the model
        repeat (1500) begin
            int r;
            dataA = $urandom;
            dataB = $urandom;
            valid = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 3);
            Signal = (r == 0) ? F_MULTU : (r == 1) ? F_MFHI : (r == 2) ? F_MFLO : 6'($urandom);
            tick();
        end
        valid  = 1'b0;
        Signal = 6'h00;
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
